// File: rtl/mb_pkg.sv
// mb_pkg: shared FSM state, MB source codes and word pointer type for the MB select controller
package mb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MWAIT, S_DONE} mb_state_t;
  localparam logic [2:0] MBSEL_AR    = 3'd0;
  localparam logic [2:0] MBSEL_CACHE = 3'd1;
  localparam logic [2:0] MBSEL_MEM   = 3'd2;
  localparam logic [2:0] MBSEL_CHBUF = 3'd3;
  typedef logic [1:0] wd_ptr_t;
endpackage

// File: rtl/mb_wd_seq.sv
// mb_wd_seq: MB word pointer/count stepper with modulo-4 wrap, direction and last-word flag
module mb_wd_seq
  import mb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  wd_ptr_t    first_i,
  input  logic [2:0] cnt_i,
  input  logic       desc_i,
  output wd_ptr_t    ptr_o,
  output logic       last_o
);
  wd_ptr_t    ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       desc_q, desc_d;
  always_comb begin
    ptr_d  = load_i ? first_i : step_i ? (desc_q ? ptr_q - 2'd1 : ptr_q + 2'd1) : ptr_q;
    cnt_d  = load_i ? ((cnt_i == 3'd0) ? 3'd4 : cnt_i) : step_i ? cnt_q - 3'd1 : cnt_q;
    desc_d = load_i ? desc_i : desc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      desc_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      desc_q <= desc_d;
    end
  end
  assign ptr_o  = ptr_q;
  assign last_o = (cnt_q == 3'd1);
endmodule

// File: rtl/mb_sel_ctl.sv
// mb_sel_ctl: MB source arbitration, select and per-word hold sequencing (MB_CH_REVERSE_EN enables descending channel transfers)
module mb_sel_ctl
  import mb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_mb_ctl_h,
  input  logic       mr_reset_h,
  input  logic       mem_req_h,
  input  logic [1:0] mem_first_wd_h,
  input  logic [2:0] mem_wd_cnt_h,
  input  logic       mem_data_valid_h,
  input  logic       ch_req_h,
  input  logic [1:0] ch_first_wd_h,
  input  logic [2:0] ch_wd_cnt_h,
  input  logic       ch_reverse_h,
  input  logic       cache_req_h,
  input  logic [1:0] cache_wd_h,
  input  logic       ar_req_h,
  input  logic [1:0] ar_wd_h,
  output logic       mem_gnt_h,
  output logic       ch_gnt_h,
  output logic       cache_gnt_h,
  output logic       ar_gnt_h,
  output logic       mb_in_sel_1_h,
  output logic       mb_in_sel_2_h,
  output logic       mb_in_sel_4_h,
  output logic [3:0] mb_hold_in_h,
  output logic       mb_sel_hold_h,
  output logic       mb_done_h,
  output logic       mb_nxm_h,
  output logic       mb_busy_h
);
  localparam logic [5:0] TMO = 6'(MEM_TIMEOUT - 1);
  mb_state_t  state_q, state_d;
  logic [3:0] gnt_q, gnt_d, req_gnt;
  logic [2:0] sel_q, sel_d, req_sel, req_cnt;
  logic [5:0] tmr_q, tmr_d;
  logic       nxm_q, nxm_d, any_req, req_desc, load, step, last;
  wd_ptr_t    req_first, ptr;
  assign any_req   = mem_req_h | ch_req_h | cache_req_h | ar_req_h;
  assign req_gnt   = mem_req_h ? 4'b0001 : ch_req_h ? 4'b0010 : cache_req_h ? 4'b0100 : 4'b1000;
  assign req_sel   = mem_req_h ? MBSEL_MEM : ch_req_h ? MBSEL_CHBUF : cache_req_h ? MBSEL_CACHE : MBSEL_AR;
  assign req_first = mem_req_h ? mem_first_wd_h : ch_req_h ? ch_first_wd_h : cache_req_h ? cache_wd_h : ar_wd_h;
  assign req_cnt   = mem_req_h ? mem_wd_cnt_h : ch_req_h ? ch_wd_cnt_h : 3'd1;
`ifdef MB_CH_REVERSE_EN
  assign req_desc  = !mem_req_h && ch_req_h && ch_reverse_h;
`else
  assign req_desc  = ch_reverse_h & 1'b0;
`endif
  mb_wd_seq u_seq (
    .clk    (clk_mb_ctl_h),
    .rst    (mr_reset_h),
    .load_i (load),
    .step_i (step),
    .first_i(req_first),
    .cnt_i  (req_cnt),
    .desc_i (req_desc),
    .ptr_o  (ptr),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    nxm_d   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: if (any_req) begin
        load    = 1'b1;
        gnt_d   = req_gnt;
        sel_d   = req_sel;
        tmr_d   = '0;
        state_d = mem_req_h ? S_MWAIT : S_LOAD;
      end
      S_LOAD: begin
        step    = 1'b1;
        state_d = last ? S_DONE : S_LOAD;
      end
      S_MWAIT: if (mem_data_valid_h) begin
        step    = 1'b1;
        tmr_d   = '0;
        state_d = last ? S_DONE : S_MWAIT;
      end else if (tmr_q == TMO) begin
        state_d = S_IDLE;
        gnt_d   = '0;
        nxm_d   = 1'b1;
      end else begin
        tmr_d   = tmr_q + 6'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk_mb_ctl_h) begin
    if (mr_reset_h) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= MBSEL_AR;
      tmr_q   <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
      nxm_q   <= nxm_d;
    end
  end
  assign {ar_gnt_h, cache_gnt_h, ch_gnt_h, mem_gnt_h}    = gnt_q;
  assign {mb_in_sel_4_h, mb_in_sel_2_h, mb_in_sel_1_h} = sel_q;
  assign mb_hold_in_h  = (state_q == S_LOAD || (state_q == S_MWAIT && mem_data_valid_h)) ? ~(4'b0001 << ptr) : 4'hF;
  assign mb_sel_hold_h = (state_q == S_IDLE);
  assign mb_done_h     = (state_q == S_DONE);
  assign mb_nxm_h      = nxm_q;
  assign mb_busy_h     = (state_q != S_IDLE);
endmodule

// File: doc/mb_sel_ctl.md
MB_SEL_CTL -- requirements
Module: mb_sel_ctl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles to wait per memory word before abort; legal range 1..63.
REQ-002 clk_mb_ctl_h  in  1  block clock; all state changes on its rising edge.
REQ-003 mr_reset_h  in  1  reset, synchronous, active-high.
REQ-004 mem_req_h  in  1  memory quadword load request; level, held until done/nxm.
REQ-005 mem_first_wd_h  in  2  first word number of the memory transfer.
REQ-006 mem_wd_cnt_h  in  3  words to load, 1..4; 0 is treated as 4.
REQ-007 mem_data_valid_h  in  1  the current memory word is on mem_data_in this cycle.
REQ-008 ch_req_h / ch_first_wd_h[1:0] / ch_wd_cnt_h[2:0]  in  1/2/3  channel-buffer load request, same meaning as the memory fields; one word per cycle, always valid.
REQ-009 ch_reverse_h  in  1  channel transfer runs in descending word order.
REQ-010 cache_req_h / cache_wd_h[1:0]  in  1/2  single-word load from cache data.
REQ-011 ar_req_h / ar_wd_h[1:0]  in  1/2  single-word load from AR.
REQ-012 mem_gnt_h, ch_gnt_h, cache_gnt_h, ar_gnt_h  out  1 each  one-hot grant, held for the whole transfer.
REQ-013 mb_in_sel_1_h, mb_in_sel_2_h, mb_in_sel_4_h  out  1 each  MB source code bits: 0=AR, 1=cache, 2=memory, 3=channel buffer.
REQ-014 mb_hold_in_h  out  4  per-word hold; bit n=0 loads MB word n this cycle, bit n=1 holds it.
REQ-015 mb_sel_hold_h  out  1  freezes the source select; high whenever idle.
REQ-016 mb_done_h  out  1  one-cycle pulse when a transfer completes normally.
REQ-017 mb_nxm_h  out  1  one-cycle pulse when a memory word times out.
REQ-018 mb_busy_h  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM has four states: IDLE, LOAD, MWAIT and DONE.
REQ-020 In IDLE, the fixed priority is mem > ch > cache > ar; the grant, select code, word pointer and remaining count are registered, and the next state is LOAD (memory: MWAIT).
REQ-021 Every MB load occurs exactly one cycle after the grant edge; there is no combinational path from request inputs to mb_hold_in_h.
REQ-022 In LOAD, exactly one mb_hold_in_h bit (the current pointer) is 0 per cycle; the pointer then steps, the count decrements, and at count 1 the next state is DONE.
REQ-023 In MWAIT, all holds are 1 until mem_data_valid_h; the valid word is loaded that same cycle, and the FSM stays in MWAIT for the next word or goes to DONE on the last word.
REQ-024 The word pointer wraps modulo 4: ascending 3→0, descending 0→3. For example, first word 2 with count 4 gives the order 2,3,0,1.
REQ-025 The timeout counter clears on each valid word; when it reaches MEM_TIMEOUT without valid, mb_nxm_h pulses, all holds go to 1 and the next state is IDLE, with no mb_done_h.
REQ-026 DONE pulses mb_done_h for one cycle, drops the grant and returns to IDLE; a new grant is issued no earlier than the cycle after DONE.
REQ-027 A request dropped mid-transfer is ignored; the transfer runs to completion.
REQ-028 Simultaneous requests are resolved purely by priority; losing requesters stay pending.
REQ-029 Cache and AR transfers are always count 1, with no MWAIT state.

Reset
REQ-030 While mr_reset_h is sampled high, the FSM goes to IDLE, all grants, done, nxm and busy go to 0, mb_hold_in_h goes to 4'hF, mb_sel_hold_h goes to 1, the select code goes to 0, and all counters clear.
REQ-031 Reset asserted mid-transfer aborts it without a done or nxm pulse; the first grant can occur in the cycle after reset deasserts.

Configuration
REQ-032 With MB_CH_REVERSE_EN defined, ch_reverse_h=1 makes channel transfers step descending.
REQ-033 Without MB_CH_REVERSE_EN, ch_reverse_h is ignored and all transfers step ascending.
REQ-034 Memory, cache and AR transfers are always ascending, whether or not the macro is defined.

Structure
REQ-035 The shared package mb_pkg holds the FSM state enum, the 3-bit select code constants (MBSEL_AR, MBSEL_CACHE, MBSEL_MEM, MBSEL_CHBUF) and the type of the 2-bit word pointer.
REQ-036 One sub-module, mb_wd_seq, implements the pointer/count stepper (load, step, wrap, direction, last flag) and is instantiated once.

Verification
REQ-037 Memory request, first word 2, count 4, valid every cycle → holds in successive cycles are 1011, 0111, 1110, 1101; mb_done_h pulses 1 cycle after the last load; select code = 2.
REQ-038 Memory request with no valid and MEM_TIMEOUT=15 → mb_nxm_h pulses exactly 15 cycles after the grant; no mb_done_h; all holds stay 1111.
REQ-039 mem, ch, cache and ar requests all asserted together → grants issued in the order mem, ch, cache, ar, each starting the cycle after the previous DONE.
REQ-040 Channel request, first word 1, count 3, reverse=1 → loads words 1, 0, 3 with the macro defined, and words 1, 2, 3 without it.
REQ-041 Reset asserted on the 2nd word of a 4-word memory transfer → next cycle is IDLE, holds 1111, no done/nxm; a cache request after reset is granted with select code 1.
